// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate kinds, ALU op codes,
// operand-A selects and the packed decoded bundle held by the decode stage.
// Optional RV32M decode is enabled with the ID_RV32M_EN macro (see id_decode).
package riscv_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate formats
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // ALU operations
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  // ALU operand A sources
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // Decoded bundle; imm is the 32-bit sign-extended immediate, widened to XLEN at the stage output.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic        alu_rs2_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  // Build the sign-extended immediate for the given format.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input logic [2:0] kind);
    logic [31:0] r;
    r = 32'd0;
    case (kind)
      IMM_I:   r = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   r = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   r = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   r = {inst[31:12], 12'd0};
      IMM_J:   r = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I instruction -> decoded bundle, including immediate generation.
// Zero latency; no handshake. R-type carries imm=0.
// Macro ID_RV32M_EN: when defined, OP with funct7=0x01 decodes to the RV32M ops.
module id_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [2:0] imm_kind;
  logic       ill;

  assign opcode = inst[6:0];
  assign f7     = inst[31:25];
  assign f3     = inst[14:12];

  // Field extraction, per-opcode control and legality, then illegal/x0 masking.
  always_comb begin
    dec          = '0;
    imm_kind     = IMM_NONE;
    ill          = 1'b0;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.funct3   = f3;
    dec.alu_op   = ALU_ADD;
    dec.alu_src_a = SRC_A_RS1;

    case (opcode)
      OPC_OP_IMM: begin
        imm_kind        = IMM_I;
        dec.alu_rs2_imm = 1'b1;
        dec.reg_write   = 1'b1;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            ill        = (f7 != 7'h00);
          end
          default: begin
            if (f7 == 7'h00)      dec.alu_op = ALU_SRL;
            else if (f7 == 7'h20) dec.alu_op = ALU_SRA;
            else                  ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
          else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
          else                   ill = 1'b1;
        end else if (f7 == 7'h01) begin
`ifdef ID_RV32M_EN
          dec.alu_op = ALU_MUL + {2'b00, f3};
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        imm_kind        = IMM_I;
        dec.alu_rs2_imm = 1'b1;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        ill             = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm_kind        = IMM_S;
        dec.alu_rs2_imm = 1'b1;
        dec.mem_write   = 1'b1;
        ill             = (f3[2] == 1'b1) || (f3 == 3'b011);
      end
      OPC_BRANCH: begin
        imm_kind   = IMM_B;
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        ill        = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI: begin
        imm_kind        = IMM_U;
        dec.alu_src_a   = SRC_A_ZERO;
        dec.alu_rs2_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_kind        = IMM_U;
        dec.alu_src_a   = SRC_A_PC;
        dec.alu_rs2_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        imm_kind        = IMM_J;
        dec.alu_src_a   = SRC_A_PC;
        dec.alu_rs2_imm = 1'b1;
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OPC_JALR: begin
        imm_kind        = IMM_I;
        dec.alu_rs2_imm = 1'b1;
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        ill             = (f3 != 3'b000);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm_kind = IMM_I;
      end
      default: ill = 1'b1;
    endcase

    dec.imm     = gen_imm(inst, imm_kind);
    dec.illegal = ill;
    if (ill) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage with a two-entry (main + skid) output buffer.
// Latency 1 cycle accept->out_valid; in_ready is a function of state only (low in TWO).
// Flush empties the buffer next cycle. Macro ID_RV32M_EN enables RV32M decode in id_decode.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_op,
  output logic [1:0]      alu_src_a,
  output logic            alu_rs2_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]      state;
  dec_t            dec;
  dec_t            main_q;
  dec_t            skid_q;
  logic [PC_W-1:0] main_pc;
  logic [PC_W-1:0] skid_pc;
  logic            accept;

  id_decode u_decode (
    .inst (in_inst),
    .dec  (dec)
  );

  // Skid occupancy is exactly state TWO, so in_ready comes straight from the state flops.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;

  // Buffer occupancy: flush wins over any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !out_ready)      state <= ST_TWO;
          else if (!accept && out_ready) state <= ST_EMPTY;
        end
        ST_TWO:   if (out_ready) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Payload movement; main only changes when empty or being consumed, keeping outputs stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      main_pc <= '0;
      skid_pc <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q  <= dec;
            main_pc <= in_pc;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            main_q  <= dec;
            main_pc <= in_pc;
          end else if (accept) begin
            skid_q  <= dec;
            skid_pc <= in_pc;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_pc      = main_pc;
  assign rs1_addr    = main_q.rs1;
  assign rs2_addr    = main_q.rs2;
  assign rd_addr     = main_q.rd;
  assign funct3      = main_q.funct3;
  assign imm         = XLEN'($signed(main_q.imm));
  assign alu_op      = main_q.alu_op;
  assign alu_src_a   = main_q.alu_src_a;
  assign alu_rs2_imm = main_q.alu_rs2_imm;
  assign reg_write   = main_q.reg_write;
  assign mem_read    = main_q.mem_read;
  assign mem_write   = main_q.mem_write;
  assign branch      = main_q.branch;
  assign jump        = main_q.jump;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: expected bundles are queued on accept and compared on each output transfer.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic [4:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic        alu_rs2_imm, reg_write, mem_read, mem_write, branch, jump, illegal;

  id_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .funct3(funct3), .imm(imm), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_rs2_imm(alu_rs2_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [4:0]  rd;
    logic [1:0]  sa;
    logic        r2i, rw, mr, mw, br, jmp, ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e, mon_act;
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] im,
                              input logic [4:0] alu, input logic [4:0] rd, input logic [1:0] sa,
                              input logic r2i, input logic rw, input logic mr, input logic mw,
                              input logic br, input logic jmp, input logic ill);
    exp_t e;
    e.pc = pc; e.imm = im; e.alu = alu; e.rd = rd; e.sa = sa;
    e.r2i = r2i; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jmp = jmp; e.ill = ill;
    return e;
  endfunction

  // Scoreboard: pop/compare each transfer, then queue whatever fetch hands over this cycle.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        mon_act = mk(out_pc, imm, alu_op, rd_addr, alu_src_a, alu_rs2_imm, reg_write,
                     mem_read, mem_write, branch, jump, illegal);
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out pc=%h got a bundle, required none", out_pc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_act !== mon_e)
            begin
              failures++;
              $display("FAIL bundle got pc=%h imm=%h alu=%0d rd=%0d ctl=%b required pc=%h imm=%h alu=%0d rd=%0d ctl=%b",
                       mon_act.pc, mon_act.imm, mon_act.alu, mon_act.rd,
                       {mon_act.sa, mon_act.r2i, mon_act.rw, mon_act.mr, mon_act.mw, mon_act.br, mon_act.jmp, mon_act.ill},
                       mon_e.pc, mon_e.imm, mon_e.alu, mon_e.rd,
                       {mon_e.sa, mon_e.r2i, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.br, mon_e.jmp, mon_e.ill});
            end
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; cur_exp = e;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout pc=%h got in_ready=0 for 20 cycles, required accept", pc);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < n; i++) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    checks++; if (imm !== 32'd0) begin failures++; $display("FAIL reset_imm got %h required 0", imm); end
    checks++; if (alu_op !== 5'd0 || illegal !== 1'b0 || reg_write !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got alu=%0d ill=%b rw=%b required 0 0 0", alu_op, illegal, reg_write);
    end
  endtask

  task automatic test_addi;
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h100, mk(32'h100, 32'hFFFFFFFF, 5'd0, 5'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    idle(1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_latency got out_valid=%b required 1", out_valid); end
    checks++; if (imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_imm got %h required ffffffff", imm); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send(32'h402081B3, 32'h200, mk(32'h200, 32'd0, 5'd1, 5'd3, 2'd0, 0, 1, 0, 0, 0, 0, 0));
    send(32'h00208033, 32'h204, mk(32'h204, 32'd0, 5'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got %b required 1", out_valid); end
    send(32'h0020A223, 32'h208, mk(32'h208, 32'd4, 5'd0, 5'd4, 2'd0, 1, 0, 0, 1, 0, 0, 0));
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got %b required 1", out_valid); end
    idle(1);
    @(negedge clk);
    checks++; if (out_pc !== 32'h208 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_last got pc=%h v=%b required 208 1", out_pc, out_valid);
    end
    idle(1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'h00100093, 32'h300, mk(32'h300, 32'd1, 5'd0, 5'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    send(32'h00200113, 32'h304, mk(32'h304, 32'd2, 5'd0, 5'd2, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_inst = 32'h00300193; in_pc = 32'h308;
    cur_exp = mk(32'h308, 32'd3, 5'd0, 5'd3, 2'd0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || imm !== 32'd1) begin
        failures++; $display("FAIL bp_stable got v=%b pc=%h imm=%h required 1 300 1", out_valid, out_pc, imm);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    send(32'h00300193, 32'h308, mk(32'h308, 32'd3, 5'd0, 5'd3, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_decode_mix;
    out_ready = 1'b1;
    send(32'h00208463, 32'h400, mk(32'h400, 32'd8, 5'd1, 5'd8, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    send(32'hFFDFF0EF, 32'h404, mk(32'h404, 32'hFFFFFFFC, 5'd0, 5'd1, 2'd1, 1, 1, 0, 0, 0, 1, 0));
    send(32'hFF812283, 32'h408, mk(32'h408, 32'hFFFFFFF8, 5'd0, 5'd5, 2'd0, 1, 1, 1, 0, 0, 0, 0));
    send(32'h123453B7, 32'h40C, mk(32'h40C, 32'h12345000, 5'd0, 5'd7, 2'd2, 1, 1, 0, 0, 0, 0, 0));
    send(32'h00001117, 32'h410, mk(32'h410, 32'h00001000, 5'd0, 5'd2, 2'd1, 1, 1, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    send(32'h402091B3, 32'h500, mk(32'h500, 32'd0, 5'd0, 5'd3, 2'd0, 0, 0, 0, 0, 0, 0, 1));
    send(32'h000090E7, 32'h504, mk(32'h504, 32'd0, 5'd0, 5'd1, 2'd0, 1, 0, 0, 0, 0, 0, 1));
    send(32'h0000007F, 32'h508, mk(32'h508, 32'd0, 5'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
    send(32'h0020A463, 32'h50C, mk(32'h50C, 32'd8, 5'd1, 5'd8, 2'd0, 0, 0, 0, 0, 0, 0, 1));
    send(32'hFF813283, 32'h510, mk(32'h510, 32'hFFFFFFF8, 5'd0, 5'd5, 2'd0, 1, 0, 0, 0, 0, 0, 1));
    idle(3);
  endtask

  task automatic test_mul;
    out_ready = 1'b1;
`ifdef ID_RV32M_EN
    send(32'h022081B3, 32'h600, mk(32'h600, 32'd0, 5'd10, 5'd3, 2'd0, 0, 1, 0, 0, 0, 0, 0));
`else
    send(32'h022081B3, 32'h600, mk(32'h600, 32'd0, 5'd0, 5'd3, 2'd0, 0, 0, 0, 0, 0, 0, 1));
`endif
    idle(3);
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    send(32'h00100093, 32'h700, mk(32'h700, 32'd1, 5'd0, 5'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    send(32'h00200113, 32'h704, mk(32'h704, 32'd2, 5'd0, 5'd2, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_inst = 32'h00300193; in_pc = 32'h708; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_two got v=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    send(32'h00100093, 32'h710, mk(32'h710, 32'd1, 5'd0, 5'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_inst = 32'h00200113; in_pc = 32'h714; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_accept got v=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send(32'h00300193, 32'h718, mk(32'h718, 32'd3, 5'd0, 5'd3, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    idle(4);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send(32'h00100093, 32'h800, mk(32'h800, 32'd1, 5'd0, 5'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    send(32'h00200113, 32'h804, mk(32'h804, 32'd2, 5'd0, 5'd2, 2'd0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm !== 32'd0) begin
      failures++; $display("FAIL async_reset got v=%b rdy=%b imm=%h required 0 1 0", out_valid, in_ready, imm);
    end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h123453B7, 32'h808, mk(32'h808, 32'h12345000, 5'd0, 5'd7, 2'd2, 1, 1, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_backpressure;
    test_decode_mix;
    test_illegal;
    test_mul;
    test_flush;
    test_async_reset;
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL drain got %0d undelivered bundles required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
